lfsr_result_uart: RTL and testbench



---
 rtl/lfsr_result_uart.sv | 159 +++++++++++++++
 tb/tb_lfsr_result_uart.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_result_uart.sv
// lfsr_result_uart: captures each result of the pseudo-random generator on the
// falling edge of its busy flag, queues it in a small circular FIFO and sends
// every queued result off-chip as an 8N1 UART frame (LSB first, line idles high).
//
// Handshake: the generator has no ready. A capture is busy_d & ~busy_in; it is
// accepted when the FIFO is not full (judged on the pre-edge count) and dropped
// otherwise, which sets the sticky overflow flag. The UART side pops the FIFO
// head whenever it is idle and the FIFO is non-empty.
module lfsr_result_uart #(
  parameter int DWIDTH  = 8,
  parameter int DEPTH   = 8,
  parameter int CLK_DIV = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [DWIDTH-1:0]        num_in,
  input  logic                     busy_in,
  input  logic                     clr_ovf_i,
  output logic                     tx_o,
  output logic                     tx_busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DWIDTH + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DWIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic                busy_d;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]       head, tail;
  logic [AW:0]         count;
  logic [TW-1:0]       timer, timer_n;
  logic [BW-1:0]       bit_idx, bit_idx_n;
  logic [DWIDTH-1:0]   shift, shift_n;
  logic                tx_n;
  logic                capture, full, push, pop, bit_end;

  assign capture      = busy_d & ~busy_in;
  assign full         = (count == FULL_CNT);
  assign push         = capture & ~full;
  assign bit_end      = (timer == TIMER_MAX);
  assign fifo_count_o = count;
  assign tx_busy_o    = (state != IDLE);

  // Delayed busy flag for falling-edge detection; resets low so a generator
  // already busy at reset release cannot produce a false capture.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) busy_d <= 1'b0;
    else          busy_d <= busy_in;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[tail] <= num_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                overflow_o <= 1'b0;
    else if (capture && full)    overflow_o <= 1'b1;
    else if (clr_ovf_i)          overflow_o <= 1'b0;
  end

  // TX state register and the registered serial line.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_o    <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx_o    <= tx_n;
    end
  end

  // TX next-state: each of START, every DATA bit and STOP lasts CLK_DIV cycles;
  // the line value is derived from the next state so tx_o is a clean register.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    tx_n      = 1'b1;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_n   = mem[head];
          timer_n   = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_n = '0;
          state_n = DATA;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n   = '0;
          shift_n   = shift >> 1;
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) state_n = STOP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_lfsr_result_uart.sv
// Bench for lfsr_result_uart: directed captures push expected bytes into a
// queue; an independent UART receiver decodes tx_o and pops/compares frames.
module tb_lfsr_result_uart;

  localparam int DW      = 8;
  localparam int DEPTH   = 8;
  localparam int CLK_DIV = 16;

  logic                    clk;
  logic                    rst;
  logic [DW-1:0]           num_in;
  logic                    busy_in;
  logic                    clr_ovf_i;
  logic                    tx_o;
  logic                    tx_busy_o;
  logic [$clog2(DEPTH):0]  fifo_count_o;
  logic                    overflow_o;

  logic [DW-1:0] exp_q[$];
  int            errors;
  int            checks;

  lfsr_result_uart #(.DWIDTH(DW), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .num_in       (num_in),
    .busy_in      (busy_in),
    .clr_ovf_i    (clr_ovf_i),
    .tx_o         (tx_o),
    .tx_busy_o    (tx_busy_o),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one-cycle busy pulse; the falling edge is sampled at the next posedge
  task automatic capture(input logic [DW-1:0] v);
    @(negedge clk);
    num_in  = v;
    busy_in = 1'b1;
    @(negedge clk);
    busy_in = 1'b0;
  endtask

  task automatic capture_exp(input logic [DW-1:0] v);
    exp_q.push_back(v);
    capture(v);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy_o || fifo_count_o != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < budget), 32'd1);
  endtask

  // monitor: UART receiver sampling mid-bit, compares against the scoreboard
  logic          rx_act;
  int            rx_cnt;
  logic [DW+1:0] rx_bits;
  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
      rx_cnt = 0;
    end else begin
      if (!rx_act && tx_o == 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
      if (rx_act) begin
        if (rx_cnt % CLK_DIV == CLK_DIV / 2) begin
          rx_bits[rx_cnt / CLK_DIV] = tx_o;
          if (rx_cnt / CLK_DIV == DW + 1) begin
            rx_act = 1'b0;
            if (exp_q.size() == 0) begin
              chk("unexpected_frame", 32'(rx_bits), 32'hFFFF_FFFF);
            end else begin
              chk("frame", 32'(rx_bits), 32'({1'b1, exp_q.pop_front(), 1'b0}));
            end
          end
        end
        rx_cnt++;
      end
    end
  end

  logic [DW-1:0] wrap_vec [20];
  int n;

  initial begin
    wrap_vec = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0,
                 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1,
                 8'h7E, 8'h81, 8'h3C, 8'hC3};
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    num_in    = '0;
    busy_in   = 1'b0;
    clr_ovf_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_busy", 32'(tx_busy_o), 32'd0);
    chk("rst_count", 32'(fifo_count_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single result 0xA5: start bit two edges after the capture edge, 160 busy cycles
    capture_exp(8'hA5);
    @(negedge clk);
    chk("t1_count_after_push", 32'(fifo_count_o), 32'd1);
    chk("t1_line_idle", 32'(tx_o), 32'd1);
    @(negedge clk);
    chk("t1_start_bit", 32'(tx_o), 32'd0);
    chk("t1_busy", 32'(tx_busy_o), 32'd1);
    chk("t1_count_after_pop", 32'(fifo_count_o), 32'd0);
    n = 0;
    while (tx_busy_o && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(n), 32'd160);
    drain(500);

    // burst of 11 captures 4 cycles apart: 1 goes out, 2..9 queue, 10 and 11 drop
    for (int i = 1; i <= 11; i++) begin
      if (i <= 9) capture_exp(8'(i));
      else        capture(8'(i));
      repeat (2) @(negedge clk);
    end
    chk("burst_count_full", 32'(fifo_count_o), 32'd8);
    chk("burst_ovf", 32'(overflow_o), 32'd1);

    // clear alone
    @(negedge clk);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    chk("clr_alone", 32'(overflow_o), 32'd0);

    // clear together with a dropped push: set wins
    @(negedge clk);
    num_in  = 8'h0C;
    busy_in = 1'b1;
    @(negedge clk);
    busy_in   = 1'b0;
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    chk("clr_vs_drop_ovf", 32'(overflow_o), 32'd1);
    chk("clr_vs_drop_count", 32'(fifo_count_o), 32'd8);
    drain(3000);
    @(negedge clk);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    chk("clr_after_burst", 32'(overflow_o), 32'd0);

    // wrap-around: 20 results spaced 200 cycles apart
    for (int i = 0; i < 20; i++) begin
      capture_exp(wrap_vec[i]);
      repeat (198) @(negedge clk);
    end
    drain(1000);
    chk("wrap_ovf", 32'(overflow_o), 32'd0);
    chk("wrap_count", 32'(fifo_count_o), 32'd0);

    // reset during DATA bit 3 of 0x00 with three entries queued; frame is abandoned
    capture(8'h00);
    repeat (2) @(negedge clk);
    capture(8'h11);
    repeat (2) @(negedge clk);
    capture(8'h22);
    repeat (2) @(negedge clk);
    capture(8'h33);
    repeat (2) @(negedge clk);
    repeat (57) @(negedge clk);
    chk("mid_count", 32'(fifo_count_o), 32'd3);
    chk("mid_busy", 32'(tx_busy_o), 32'd1);
    chk("mid_data_bit3", 32'(tx_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx_o), 32'd1);
    chk("mid_rst_count", 32'(fifo_count_o), 32'd0);
    chk("mid_rst_busy", 32'(tx_busy_o), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    capture_exp(8'h3C);
    drain(500);

    // reset released with busy_in already high: exactly one frame
    @(negedge clk);
    rst     = 1'b1;
    busy_in = 1'b1;
    num_in  = 8'h5A;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_high_no_capture", 32'(fifo_count_o), 32'd0);
    exp_q.push_back(8'h5A);
    busy_in = 1'b0;
    drain(500);

    // busy_in held low: nothing further is captured or sent
    repeat (300) @(negedge clk);
    chk("quiet_count", 32'(fifo_count_o), 32'd0);
    chk("quiet_busy", 32'(tx_busy_o), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
